parity_rr_sched: RTL

Round-robin scheduler that shares a single 9-bit parity generator among several requesters. Each requester offers a data word and a parity-mode bit over a valid/ready handshake. The block grants one requester per cycle and computes even parity (XOR-reduce) or odd parity (its complement) for the granted word. It presents the word, parity bit and requester ID through a one-deep registered output stage with its own valid/ready handshake. It sits between the per-channel framers and the shared link/transmit path.

---
 rtl/parity_rr_sched_if.sv | 30 +++
 rtl/parity_rr_sched.sv | 92 +++++++++
 2 files changed

// File: rtl/parity_rr_sched_if.sv
// Bundle between requesters, the shared parity scheduler and the downstream link.
// A transfer on either side happens on a rising edge where valid && ready is high.
interface parity_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int W     = 9,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_odd;
  logic [N_REQ-1:0]   req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic               out_parity;
  logic [IDW-1:0]     out_id;
  logic [15:0]        out_count;

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, req_odd, out_ready,
    output req_ready, out_valid, out_data, out_parity, out_id, out_count
  );

  // Requesters plus downstream consumer.
  modport master (
    output req_valid, req_data, req_odd, out_ready,
    input  req_ready, out_valid, out_data, out_parity, out_id, out_count
  );
endinterface

// File: rtl/parity_rr_sched.sv
// Round-robin share of one parity generator among N_REQ requesters, with a
// one-deep registered output stage and a saturating transfer counter.
module parity_rr_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 9,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  parity_rr_sched_if.slave    bus
);

  logic [IDW-1:0] r_last;
  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic           r_out_parity;
  logic [IDW-1:0] r_out_id;
  logic [15:0]    r_out_count;

  logic           w_can_load;
  logic           w_found;
  logic [IDW-1:0] w_gnt;
  logic           w_load;
  logic [W-1:0]   w_sel_data;
  logic           w_sel_parity;
  logic [N_REQ-1:0] w_req_ready;
  logic           w_drain;

  // The stage can take a new word when it is empty or being drained this cycle.
  assign w_can_load = !r_out_valid || bus.out_ready;
  assign w_drain    = r_out_valid && bus.out_ready;

  // Search starts just after the last winner and wraps modulo N_REQ.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_gnt   = '0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(r_last) + k) % N_REQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(idx);
      end
    end
  end

  assign w_load = w_can_load && w_found && !rst;

  always_comb begin
    w_sel_data   = bus.req_data[int'(w_gnt)*W +: W];
    w_sel_parity = (^w_sel_data) ^ bus.req_odd[w_gnt];
    w_req_ready  = '0;
    if (w_load) begin
      w_req_ready[w_gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last       <= IDW'(N_REQ - 1);
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_parity <= 1'b0;
      r_out_id     <= '0;
    end else if (w_load) begin
      r_last       <= w_gnt;
      r_out_valid  <= 1'b1;
      r_out_data   <= w_sel_data;
      r_out_parity <= w_sel_parity;
      r_out_id     <= w_gnt;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_count <= '0;
    end else if (w_drain && (r_out_count != 16'hFFFF)) begin
      r_out_count <= r_out_count + 16'd1;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_parity = r_out_parity;
  assign bus.out_id     = r_out_id;
  assign bus.out_count  = r_out_count;

endmodule
